// File: rtl/axis_iic_req_arbiter_if.sv
// Bus bundle for axis_iic_req_arbiter: requester command streams, controller command
// stream, controller response stream and the routed per-requester response streams.
interface axis_iic_req_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [32*NUM_REQ-1:0] s_axis_req_tdata;
    logic [4*NUM_REQ-1:0]  s_axis_req_tkeep;
    logic [8*NUM_REQ-1:0]  s_axis_req_tdest;
    logic [NUM_REQ-1:0]    s_axis_req_tvalid;
    logic [NUM_REQ-1:0]    s_axis_req_tlast;
    logic [NUM_REQ-1:0]    s_axis_req_tready;

    logic [31:0]           m_axis_tdata;
    logic [3:0]            m_axis_tkeep;
    logic [7:0]            m_axis_tdest;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;

    logic [31:0]           s_axis_rsp_tdata;
    logic [7:0]            s_axis_rsp_tdest;
    logic                  s_axis_rsp_tvalid;
    logic                  s_axis_rsp_tlast;

    logic [32*NUM_REQ-1:0] m_axis_rsp_tdata;
    logic [8*NUM_REQ-1:0]  m_axis_rsp_tdest;
    logic [NUM_REQ-1:0]    m_axis_rsp_tvalid;
    logic [NUM_REQ-1:0]    m_axis_rsp_tlast;

    modport slave (
        input  s_axis_req_tdata, s_axis_req_tkeep, s_axis_req_tdest,
               s_axis_req_tvalid, s_axis_req_tlast,
               m_axis_tready,
               s_axis_rsp_tdata, s_axis_rsp_tdest, s_axis_rsp_tvalid, s_axis_rsp_tlast,
        output s_axis_req_tready,
               m_axis_tdata, m_axis_tkeep, m_axis_tdest, m_axis_tvalid, m_axis_tlast,
               m_axis_rsp_tdata, m_axis_rsp_tdest, m_axis_rsp_tvalid, m_axis_rsp_tlast
    );

    modport master (
        output s_axis_req_tdata, s_axis_req_tkeep, s_axis_req_tdest,
               s_axis_req_tvalid, s_axis_req_tlast,
               m_axis_tready,
               s_axis_rsp_tdata, s_axis_rsp_tdest, s_axis_rsp_tvalid, s_axis_rsp_tlast,
        input  s_axis_req_tready,
               m_axis_tdata, m_axis_tkeep, m_axis_tdest, m_axis_tvalid, m_axis_tlast,
               m_axis_rsp_tdata, m_axis_rsp_tdest, m_axis_rsp_tvalid, m_axis_rsp_tlast
    );
endinterface

// File: rtl/axis_iic_req_arbiter.sv
// Packet-atomic round-robin arbiter sharing one AXIS IIC command port, with read-response
// routing back to the issuer. Optional response timeout: define IIC_ARB_TIMEOUT_EN.
module axis_iic_req_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned RSP_TIMEOUT = 100000
) (
    input  logic                       clk,
    input  logic                       resetn,
    axis_iic_req_arbiter_if.slave      bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       stray_rsp,
    output logic                       timeout_err
);
    localparam int unsigned GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, FWD, WAIT_RSP} state_t;

    state_t                state;
    logic                  read_flag;
    logic                  first_beat;
    logic [GW-1:0]         win_id;
    logic                  win_found;
    logic [GW-1:0]         cand;
    logic                  fwd_hs;
    logic                  pkt_read;
    logic [32*NUM_REQ-1:0] rsp_tdata;
    logic [8*NUM_REQ-1:0]  rsp_tdest;
    logic [NUM_REQ-1:0]    rsp_tvalid;
    logic [NUM_REQ-1:0]    rsp_tlast;
    logic                  stray_q;
`ifdef IIC_ARB_TIMEOUT_EN
    logic [31:0]           wait_cnt;
    logic                  tmo_q;
`endif

    // Round-robin search starting just after the last owner
    always_comb begin
        win_found = 1'b0;
        win_id    = grant_id;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((32'(grant_id) + k) % NUM_REQ);
            if (!win_found && bus.s_axis_req_tvalid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        bus.m_axis_tdata      = '0;
        bus.m_axis_tkeep      = '0;
        bus.m_axis_tdest      = '0;
        bus.m_axis_tvalid     = 1'b0;
        bus.m_axis_tlast      = 1'b0;
        bus.s_axis_req_tready = '0;
        if (state == FWD) begin
            bus.m_axis_tdata  = bus.s_axis_req_tdata[32*grant_id +: 32];
            bus.m_axis_tkeep  = bus.s_axis_req_tkeep[4*grant_id +: 4];
            bus.m_axis_tdest  = bus.s_axis_req_tdest[8*grant_id +: 8];
            bus.m_axis_tvalid = bus.s_axis_req_tvalid[grant_id];
            bus.m_axis_tlast  = bus.s_axis_req_tlast[grant_id];
            bus.s_axis_req_tready[grant_id] = bus.m_axis_tready;
        end
    end

    assign fwd_hs   = (state == FWD) && bus.m_axis_tvalid && bus.m_axis_tready;
    // Single-beat packets decide from the live tdest; longer ones use the captured flag
    assign pkt_read = first_beat ? bus.m_axis_tdest[0] : read_flag;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            grant_id   <= GW'(NUM_REQ - 1);
            read_flag  <= 1'b0;
            first_beat <= 1'b0;
            rsp_tdata  <= '0;
            rsp_tdest  <= '0;
            rsp_tvalid <= '0;
            rsp_tlast  <= '0;
            stray_q    <= 1'b0;
`ifdef IIC_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            rsp_tvalid <= '0;
            rsp_tlast  <= '0;
            stray_q    <= 1'b0;
`ifdef IIC_ARB_TIMEOUT_EN
            tmo_q      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    stray_q <= bus.s_axis_rsp_tvalid;
                    if (win_found) begin
                        grant_id   <= win_id;
                        first_beat <= 1'b1;
                        state      <= FWD;
                    end
                end
                FWD: begin
                    stray_q <= bus.s_axis_rsp_tvalid;
                    if (fwd_hs) begin
                        first_beat <= 1'b0;
                        read_flag  <= pkt_read;
                        if (bus.m_axis_tlast) begin
                            state <= pkt_read ? WAIT_RSP : IDLE;
`ifdef IIC_ARB_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end
                    end
                end
                WAIT_RSP: begin
                    if (bus.s_axis_rsp_tvalid) begin
                        rsp_tvalid[grant_id]          <= 1'b1;
                        rsp_tlast[grant_id]           <= bus.s_axis_rsp_tlast;
                        rsp_tdata[32*grant_id +: 32]  <= bus.s_axis_rsp_tdata;
                        rsp_tdest[8*grant_id +: 8]    <= bus.s_axis_rsp_tdest;
                        if (bus.s_axis_rsp_tlast) begin
                            state <= IDLE;
                        end
`ifdef IIC_ARB_TIMEOUT_EN
                        wait_cnt <= '0;
                    end else if (wait_cnt == 32'(RSP_TIMEOUT - 1)) begin
                        state    <= IDLE;
                        tmo_q    <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_axis_rsp_tdata  = rsp_tdata;
    assign bus.m_axis_rsp_tdest  = rsp_tdest;
    assign bus.m_axis_rsp_tvalid = rsp_tvalid;
    assign bus.m_axis_rsp_tlast  = rsp_tlast;
    assign busy                  = (state != IDLE);
    assign stray_rsp             = stray_q;
`ifdef IIC_ARB_TIMEOUT_EN
    assign timeout_err           = tmo_q;
`else
    assign timeout_err           = 1'b0;
`endif
endmodule
